shape_compute_engine: RTL and testbench



---
 rtl/shape_compute_engine_if.sv | 57 +++++
 rtl/shape_compute_engine.sv | 204 ++++++++++++++++++++
 tb/tb_shape_compute_engine.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/shape_compute_engine_if.sv
// ============================================================================
// Module : shape_compute_pkg / shape_compute_engine_if
// Brief  : SFR field encodings plus command/result bundle for the engine.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package shape_compute_pkg;
   typedef enum logic [1:0] {
      SHAPE_CIRCLE    = 2'd0,
      SHAPE_RECTANGLE = 2'd1,
      SHAPE_TRIANGLE  = 2'd2,
      SHAPE_KEEP      = 2'd3
   } shape_e;

   typedef enum logic [2:0] {
      OP_PERIMETER      = 3'd0,
      OP_AREA           = 3'd1,
      OP_IS_SQUARE      = 3'd2,
      OP_IS_EQUILATERAL = 3'd3,
      OP_IS_ISOSCELES   = 3'd4,
      OP_RSVD5          = 3'd5,
      OP_RSVD6          = 3'd6,
      OP_KEEP           = 3'd7
   } operation_e;
endpackage

interface shape_compute_engine_if #(
   parameter int W  = 16,
   parameter int RW = 2*W+2
);
   import shape_compute_pkg::*;

   shape_e          shape;
   operation_e      operation;
   logic            cmd_valid;
   logic            cmd_ready;
   logic [W-1:0]    op_a;
   logic [W-1:0]    op_b;
   logic [W-1:0]    op_c;
   logic            res_valid;
   logic            res_ready;
   logic [RW-1:0]   res_data;
   logic            res_err;

   modport master (
      output shape, operation, cmd_valid, op_a, op_b, op_c, res_ready,
      input  cmd_ready, res_valid, res_data, res_err
   );

   modport slave (
      input  shape, operation, cmd_valid, op_a, op_b, op_c, res_ready,
      output cmd_ready, res_valid, res_data, res_err
   );
endinterface

`default_nettype wire

// File: rtl/shape_compute_engine.sv
// ============================================================================
// Module : shape_compute_engine
// Brief  : Shape perimeter/area/predicate engine with shift-add multiplier.
//          Define SHAPE_COMPUTE_FAST_MUL_EN for a single-cycle multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module shape_compute_engine
   import shape_compute_pkg::*;
#(
   parameter int W     = 16,
   parameter int PI_Q8 = 804,
   parameter int PI_W  = 12,
   parameter int RW    = 2*W+2
) (
   input wire                      clk,
   input wire                      rst_n,
   shape_compute_engine_if.slave   bus
);

   localparam int MW = (W > PI_W) ? W : PI_W;
   localparam int CW = $clog2(MW+1);

   localparam logic [RW-1:0] c_pi_r = RW'(PI_Q8);
   localparam logic [MW-1:0] c_pi_m = MW'(PI_Q8);

   localparam logic [3:0] c_k_err        = 4'd0;
   localparam logic [3:0] c_k_rect_perim = 4'd1;
   localparam logic [3:0] c_k_rect_sq    = 4'd2;
   localparam logic [3:0] c_k_tri_perim  = 4'd3;
   localparam logic [3:0] c_k_tri_eq     = 4'd4;
   localparam logic [3:0] c_k_tri_iso    = 4'd5;
   localparam logic [3:0] c_k_circ_perim = 4'd6;
   localparam logic [3:0] c_k_circ_area  = 4'd7;
   localparam logic [3:0] c_k_rect_area  = 4'd8;
   localparam logic [3:0] c_k_tri_area   = 4'd9;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADD  = 3'd1,
      S_MUL1 = 3'd2,
      S_MUL2 = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t          r_state;
   logic [3:0]      r_kind;
   logic [W-1:0]    r_a, r_b, r_c;
   logic [RW-1:0]   r_acc, r_mcand;
   logic [MW-1:0]   r_mplier;
   logic [CW-1:0]   r_cnt;
   logic            r_cmd_ready, r_res_valid, r_res_err;
   logic [RW-1:0]   r_res_data;

   logic [3:0]      w_kind;
   logic            w_is_mul;
   logic [RW-1:0]   w_step, w_acc_next, w_add_res;
   logic            w_mul1_last, w_mul2_last;

   // Shape/operation pair collapses to one command kind at accept time
   always_comb begin
      w_kind = c_k_err;
      case (bus.shape)
         SHAPE_CIRCLE: begin
            if (bus.operation == OP_PERIMETER)      w_kind = c_k_circ_perim;
            else if (bus.operation == OP_AREA)      w_kind = c_k_circ_area;
         end
         SHAPE_RECTANGLE: begin
            if (bus.operation == OP_PERIMETER)      w_kind = c_k_rect_perim;
            else if (bus.operation == OP_AREA)      w_kind = c_k_rect_area;
            else if (bus.operation == OP_IS_SQUARE) w_kind = c_k_rect_sq;
         end
         SHAPE_TRIANGLE: begin
            if (bus.operation == OP_PERIMETER)           w_kind = c_k_tri_perim;
            else if (bus.operation == OP_AREA)           w_kind = c_k_tri_area;
            else if (bus.operation == OP_IS_EQUILATERAL) w_kind = c_k_tri_eq;
            else if (bus.operation == OP_IS_ISOSCELES)   w_kind = c_k_tri_iso;
         end
         default: w_kind = c_k_err;
      endcase
   end

   assign w_is_mul = (w_kind == c_k_circ_perim) || (w_kind == c_k_circ_area) ||
                     (w_kind == c_k_rect_area)  || (w_kind == c_k_tri_area);

`ifdef SHAPE_COMPUTE_FAST_MUL_EN
   // r_cnt is zero on entry to each multiply phase, so each phase ends at once
   assign w_step      = r_mcand * RW'(r_mplier);
   assign w_mul1_last = (r_cnt == '0);
   assign w_mul2_last = (r_cnt == '0);
`else
   assign w_step      = r_mplier[0] ? r_mcand : '0;
   assign w_mul1_last = (r_cnt == CW'(W-1));
   assign w_mul2_last = (r_cnt == CW'(PI_W-1));
`endif
   assign w_acc_next = r_acc + w_step;

   always_comb begin
      w_add_res = '0;
      case (r_kind)
         c_k_rect_perim: w_add_res = (RW'(r_a) + RW'(r_b)) << 1;
         c_k_rect_sq:    w_add_res = RW'(r_a == r_b);
         c_k_tri_perim:  w_add_res = RW'(r_a) + RW'(r_b) + RW'(r_c);
         c_k_tri_eq:     w_add_res = RW'((r_a == r_b) && (r_b == r_c));
         c_k_tri_iso:    w_add_res = RW'((r_a == r_b) || (r_b == r_c) || (r_a == r_c));
         default:        w_add_res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_kind      <= c_k_err;
         r_a         <= '0;
         r_b         <= '0;
         r_c         <= '0;
         r_acc       <= '0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_cnt       <= '0;
         r_cmd_ready <= 1'b1;
         r_res_valid <= 1'b0;
         r_res_err   <= 1'b0;
         r_res_data  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.cmd_valid && r_cmd_ready) begin
                  r_kind      <= w_kind;
                  r_a         <= bus.op_a;
                  r_b         <= bus.op_b;
                  r_c         <= bus.op_c;
                  r_acc       <= '0;
                  r_cnt       <= '0;
                  r_mplier    <= MW'(bus.op_a);
                  r_cmd_ready <= 1'b0;
                  if (w_kind == c_k_circ_perim)     r_mcand <= c_pi_r;
                  else if (w_kind == c_k_circ_area) r_mcand <= RW'(bus.op_a);
                  else                              r_mcand <= RW'(bus.op_b);
                  r_state <= w_is_mul ? S_MUL1 : S_ADD;
               end
            end
            S_ADD: begin
               r_res_data  <= w_add_res;
               r_res_err   <= (r_kind == c_k_err);
               r_res_valid <= 1'b1;
               r_state     <= S_DONE;
            end
            S_MUL1: begin
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
               if (w_mul1_last) begin
                  if (r_kind == c_k_circ_area) begin
                     // a*a becomes the multiplicand, pi the multiplier bits
                     r_acc    <= '0;
                     r_mcand  <= w_acc_next;
                     r_mplier <= c_pi_m;
                     r_cnt    <= '0;
                     r_state  <= S_MUL2;
                  end else begin
                     if (r_kind == c_k_circ_perim)     r_res_data <= w_acc_next >> 7;
                     else if (r_kind == c_k_tri_area)  r_res_data <= w_acc_next >> 1;
                     else                              r_res_data <= w_acc_next;
                     r_res_err   <= 1'b0;
                     r_res_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end
               end
            end
            S_MUL2: begin
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
               if (w_mul2_last) begin
                  r_res_data  <= w_acc_next >> 8;
                  r_res_err   <= 1'b0;
                  r_res_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (bus.res_ready) begin
                  r_res_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.cmd_ready = r_cmd_ready;
   assign bus.res_valid = r_res_valid;
   assign bus.res_data  = r_res_data;
   assign bus.res_err   = r_res_err;

endmodule

`default_nettype wire

// File: tb/tb_shape_compute_engine.sv
// ============================================================================
// Module : tb_shape_compute_engine
// Brief  : Directed vector table plus handshake/reset sequences for the engine.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_shape_compute_engine;
   import shape_compute_pkg::*;

   localparam int W  = 16;
   localparam int RW = 2*W+2;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   shape_compute_engine_if #(.W(W), .RW(RW)) bus ();

   shape_compute_engine #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      shape_e        shape;
      operation_e    op;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [W-1:0]  c;
      logic [RW-1:0] data;
      logic          err;
      int            cls;   // 0 add path, 1 single multiply, 2 circle area
   } vec_t;

   vec_t vq[$];

   function automatic int exp_lat(input int cls);
`ifdef SHAPE_COMPUTE_FAST_MUL_EN
      return (cls == 2) ? 2 : 1;
`else
      return (cls == 0) ? 1 : (cls == 1) ? W : W + 12;
`endif
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   // Launch one command; returns cycles from accept edge to res_valid
   task automatic issue(input vec_t v, output int lat);
      @(negedge clk);
      bus.shape     = v.shape;
      bus.operation = v.op;
      bus.op_a      = v.a;
      bus.op_b      = v.b;
      bus.op_c      = v.c;
      bus.cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      lat = 0;
      while (!bus.res_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic consume();
      bus.res_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.res_ready = 1'b0;
   endtask

   initial begin
      int lat;
      vec_t v;
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.shape = SHAPE_CIRCLE;
      bus.operation = OP_PERIMETER;
      bus.op_a = '0; bus.op_b = '0; bus.op_c = '0;
      bus.cmd_valid = 1'b0;
      bus.res_ready = 1'b0;

      vq.push_back('{SHAPE_RECTANGLE, OP_AREA,           16'd3,     16'd5,     16'd0, 34'd15,         1'b0, 1});
      vq.push_back('{SHAPE_CIRCLE,    OP_PERIMETER,      16'd10,    16'd0,     16'd0, 34'd62,         1'b0, 1});
      vq.push_back('{SHAPE_CIRCLE,    OP_AREA,           16'd10,    16'd0,     16'd0, 34'd314,        1'b0, 2});
      vq.push_back('{SHAPE_CIRCLE,    OP_AREA,           16'd1,     16'd0,     16'd0, 34'd3,          1'b0, 2});
      vq.push_back('{SHAPE_TRIANGLE,  OP_AREA,           16'd6,     16'd4,     16'd0, 34'd12,         1'b0, 1});
      vq.push_back('{SHAPE_TRIANGLE,  OP_AREA,           16'd7,     16'd3,     16'd0, 34'd10,         1'b0, 1});
      vq.push_back('{SHAPE_TRIANGLE,  OP_IS_EQUILATERAL, 16'd5,     16'd5,     16'd5, 34'd1,          1'b0, 0});
      vq.push_back('{SHAPE_TRIANGLE,  OP_IS_EQUILATERAL, 16'd5,     16'd5,     16'd7, 34'd0,          1'b0, 0});
      vq.push_back('{SHAPE_TRIANGLE,  OP_IS_ISOSCELES,   16'd5,     16'd5,     16'd7, 34'd1,          1'b0, 0});
      vq.push_back('{SHAPE_TRIANGLE,  OP_IS_ISOSCELES,   16'd3,     16'd4,     16'd5, 34'd0,          1'b0, 0});
      vq.push_back('{SHAPE_TRIANGLE,  OP_IS_ISOSCELES,   16'd4,     16'd5,     16'd4, 34'd1,          1'b0, 0});
      vq.push_back('{SHAPE_TRIANGLE,  OP_PERIMETER,      16'd3,     16'd4,     16'd5, 34'd12,         1'b0, 0});
      vq.push_back('{SHAPE_CIRCLE,    OP_IS_SQUARE,      16'd9,     16'd9,     16'd9, 34'd0,          1'b1, 0});
      vq.push_back('{SHAPE_KEEP,      OP_AREA,           16'd9,     16'd9,     16'd9, 34'd0,          1'b1, 0});
      vq.push_back('{SHAPE_RECTANGLE, OP_KEEP,           16'd2,     16'd2,     16'd2, 34'd0,          1'b1, 0});
      vq.push_back('{SHAPE_RECTANGLE, OP_IS_SQUARE,      16'd7,     16'd7,     16'd0, 34'd1,          1'b0, 0});
      vq.push_back('{SHAPE_RECTANGLE, OP_IS_SQUARE,      16'd7,     16'd8,     16'd0, 34'd0,          1'b0, 0});
      vq.push_back('{SHAPE_RECTANGLE, OP_PERIMETER,      16'd0,     16'd0,     16'd0, 34'd0,          1'b0, 0});
      vq.push_back('{SHAPE_RECTANGLE, OP_AREA,           16'd0,     16'd9,     16'd0, 34'd0,          1'b0, 1});
      vq.push_back('{SHAPE_RECTANGLE, OP_AREA,           16'hFFFF,  16'hFFFF,  16'd0, 34'hFFFE0001,   1'b0, 1});

      repeat (2) @(posedge clk);
      #1;
      chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
      chk("rst_res_data",  64'(bus.res_data),  64'd0);
      chk("rst_res_err",   64'(bus.res_err),   64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vq[i]) begin
         issue(vq[i], lat);
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat(vq[i].cls)));
         chk($sformatf("vec%0d_data", i),    64'(bus.res_data), 64'(vq[i].data));
         chk($sformatf("vec%0d_err", i),     64'(bus.res_err),  64'(vq[i].err));
         consume();
         chk($sformatf("vec%0d_drop_valid", i), 64'(bus.res_valid), 64'd0);
         chk($sformatf("vec%0d_ready_back", i), 64'(bus.cmd_ready), 64'd1);
      end

      // Backpressure: result held for 5 cycles with res_ready low
      v = '{SHAPE_RECTANGLE, OP_PERIMETER, 16'd4, 16'd6, 16'd0, 34'd20, 1'b0, 0};
      issue(v, lat);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("hold%0d_valid", k),     64'(bus.res_valid), 64'd1);
         chk($sformatf("hold%0d_data", k),      64'(bus.res_data),  64'd20);
         chk($sformatf("hold%0d_cmd_ready", k), 64'(bus.cmd_ready), 64'd0);
         @(posedge clk);
         #1;
      end
      consume();
      chk("hold_after_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      chk("hold_after_valid",     64'(bus.res_valid), 64'd0);

      // Inputs change while a rectangle area is in flight
      @(negedge clk);
      bus.shape = SHAPE_RECTANGLE; bus.operation = OP_AREA;
      bus.op_a = 16'd3; bus.op_b = 16'd5; bus.op_c = 16'd0;
      bus.cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.shape = SHAPE_CIRCLE; bus.operation = OP_IS_SQUARE;
      bus.op_a = 16'd100; bus.op_b = 16'd200; bus.op_c = 16'd7;
      lat = 0;
      while (!bus.res_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
         bus.op_a = bus.op_a + 16'd1;
      end
      chk("inflight_latency", 64'(lat), 64'(exp_lat(1)));
      chk("inflight_data",    64'(bus.res_data), 64'd15);
      chk("inflight_err",     64'(bus.res_err),  64'd0);
      consume();

      // Reset asserted in the middle of a multiply
      v = '{SHAPE_RECTANGLE, OP_AREA, 16'd11, 16'd13, 16'd0, 34'd143, 1'b0, 1};
      @(negedge clk);
      bus.shape = v.shape; bus.operation = v.op;
      bus.op_a = v.a; bus.op_b = v.b; bus.op_c = v.c;
      bus.cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid",     64'(bus.res_valid), 64'd0);
      chk("midrst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int seen;
         seen = 0;
         repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.res_valid) seen++;
         end
         chk("midrst_no_stale", 64'(seen), 64'd0);
      end
      issue(v, lat);
      chk("postrst_latency", 64'(lat), 64'(exp_lat(1)));
      chk("postrst_data",    64'(bus.res_data), 64'd143);
      consume();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
